// File: rtl/aes128_key_expand.sv
// rtl/aes128_key_expand.sv - iterative AES-128 key schedule, one round key per valid/ready beat (option: KEY_EXP_REVERSE_EN)
module aes128_key_expand #(
    parameter int NUM_ROUNDS = 10,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [127:0]       key_in,
    output logic               busy,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [127:0]       rk_data,
    output logic [ROUND_W-1:0] rk_round,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1
`ifdef KEY_EXP_REVERSE_EN
        ,
        FILL   = 2'd2
`endif
    } state_t;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    state_t             state_q, state_d;
    logic [127:0]       key_q, key_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [7:0]         rcon_q, rcon_d;
    logic               done_q, done_d;
    logic [127:0]       next_key;
    logic [7:0]         rcon_next;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Next round key from the current one and the current rcon
    always_comb begin
        logic [31:0] t, w0, w1, w2, w3;
        t         = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0};
        w0        = key_q[127:96] ^ t;
        w1        = key_q[95:64] ^ w0;
        w2        = key_q[63:32] ^ w1;
        w3        = key_q[31:0] ^ w2;
        next_key  = {w0, w1, w2, w3};
        rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

`ifdef KEY_EXP_REVERSE_EN
    logic         buf_we;
    logic [127:0] rk_buf_q [0:NUM_ROUNDS-1];

    // Key store filled during FILL, read back in descending order while streaming
    always_ff @(posedge clk) begin
        if (buf_we) rk_buf_q[round_q] <= key_q;
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
`ifdef KEY_EXP_REVERSE_EN
        buf_we  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = '0;
                    rcon_d  = 8'h01;
`ifdef KEY_EXP_REVERSE_EN
                    state_d = FILL;
`else
                    state_d = STREAM;
`endif
                end
            end
`ifdef KEY_EXP_REVERSE_EN
            FILL: begin
                // Keys 0..NUM_ROUNDS-1 go to the store; key NUM_ROUNDS stays in key_q
                buf_we  = 1'b1;
                key_d   = next_key;
                rcon_d  = rcon_next;
                round_d = round_q + 1'b1;
                if (round_q == LAST_ROUND - 1'b1) state_d = STREAM;
            end
            STREAM: begin
                if (rk_ready) begin
                    if (round_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = rk_buf_q[round_q - 1'b1];
                        round_d = round_q - 1'b1;
                    end
                end
            end
`else
            STREAM: begin
                if (rk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = next_key;
                        round_d = round_q + 1'b1;
                        rcon_d  = rcon_next;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and key registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rk_valid = (state_q == STREAM);
    assign rk_data  = key_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes128_key_expand.sv
// tb/tb_aes128_key_expand.sv - directed self-checking bench for aes128_key_expand
module tb_aes128_key_expand;

`ifdef KEY_EXP_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk;
    logic         rst_n;
    logic         start, start_b;
    logic [127:0] key_in, key_in_b;
    logic         busy, busy_b;
    logic         rk_valid, rk_valid_b;
    logic         rk_ready, rk_ready_b;
    logic [127:0] rk_data, rk_data_b;
    logic [3:0]   rk_round, rk_round_b;
    logic         done, done_b;

    logic [127:0] exp_k [0:10];
    bit           known [0:10];
    int           checks;
    int           failures;

    aes128_key_expand #(.NUM_ROUNDS(10), .ROUND_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_round(rk_round), .done(done)
    );

    aes128_key_expand #(.NUM_ROUNDS(2), .ROUND_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .key_in(key_in_b), .busy(busy_b),
        .rk_valid(rk_valid_b), .rk_ready(rk_ready_b), .rk_data(rk_data_b),
        .rk_round(rk_round_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_key1();
        exp_k[0]  = K1;
        exp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) known[i] = 1'b1;
    endtask

    task automatic set_key2();
        for (int i = 0; i <= 10; i++) known[i] = 1'b0;
        exp_k[0]  = K2;
        exp_k[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        exp_k[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        known[0]  = 1'b1;
        known[1]  = 1'b1;
        known[10] = 1'b1;
    endtask

    task automatic run_a(input logic [127:0] key, input bit stall, input int inject);
        int  j, ph, idx, lat;
        bit  fin;
        lat = REV ? 11 : 1;
        @(negedge clk);
        start = 1'b1; key_in = key; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < lat; i++) begin
            chk("fill_valid", rk_valid, 0);
            chk("fill_busy", busy, 1);
            @(negedge clk);
        end
        chk("first_valid", rk_valid, 1);
        j = 0; ph = 0; fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            idx = REV ? 10 - j : j;
            chk("valid", rk_valid, 1);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("round", rk_round, idx[3:0]);
            if (known[idx]) chk("data", rk_data, exp_k[idx]);
            start = (inject >= 0) && (int'(rk_round) == inject);
            if (start) key_in = K2;
            rk_ready = stall ? (ph % 4 == 0 || ph % 4 == 3) : 1'b1;
            ph++;
            if (rk_ready) begin
                if (j == 10) fin = 1'b1;
                j++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("no_timeout", fin, 1);
        chk("done_pulse", done, 1);
        chk("busy_after", busy, 0);
        chk("valid_after", rk_valid, 0);
        @(negedge clk);
        chk("done_once", done, 0);
    endtask

    task automatic run_b(input logic [127:0] key);
        int  j, idx, lat;
        bit  fin;
        lat = REV ? 3 : 1;
        @(negedge clk);
        start_b = 1'b1; key_in_b = key; rk_ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 1; i < lat; i++) begin
            chk("b_fill_valid", rk_valid_b, 0);
            @(negedge clk);
        end
        j = 0; fin = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            idx = REV ? 2 - j : j;
            chk("b_valid", rk_valid_b, 1);
            chk("b_done_early", done_b, 0);
            chk("b_round", rk_round_b, idx[3:0]);
            chk("b_data", rk_data_b, exp_k[idx]);
            if (j == 2) fin = 1'b1;
            j++;
            @(negedge clk);
        end
        chk("b_no_timeout", fin, 1);
        chk("b_done_pulse", done_b, 1);
        chk("b_valid_after", rk_valid_b, 0);
        chk("b_busy_after", busy_b, 0);
        @(negedge clk);
        chk("b_done_once", done_b, 0);
    endtask

    initial begin
        bit hit;
        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
        start_b = 1'b0; key_in_b = '0; rk_ready_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", rk_data, 0);
        chk("rst_round", rk_round, 0);
        rst_n = 1'b1;

        set_key1();
        run_a(K1, 1'b0, -1);
        run_a(K1, 1'b1, -1);
        run_a(K1, 1'b0, 4);
        set_key2();
        run_a(K2, 1'b0, -1);

        set_key1();
        @(negedge clk);
        start = 1'b1; key_in = K1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (rk_valid && rk_round == 4'd6) hit = 1'b1;
            else @(negedge clk);
        end
        chk("reach_round6", hit, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", rk_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_data", rk_data, 0);
        chk("abort_round", rk_round, 0);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        rst_n = 1'b1;
        set_key2();
        run_a(K2, 1'b0, -1);

        set_key1();
        run_b(K1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
